// File: rtl/mem_range_writer.sv
// -----------------------------------------------------------------------------
// mem_range_writer
//
// Purpose:
//   Write-side counterpart of the range address counter. After a start request
//   it accepts n data words over a valid/ready stream and writes them to
//   consecutive memory addresses beginning at start_addr. Address arithmetic
//   wraps modulo 2^ADDR_W. One registered done pulse is produced per completed
//   range, coincident with the final write strobe. A zero-length range goes
//   straight to DONE and produces a done pulse with no writes.
//
// Configuration macro:
//   ABORT_EN - when defined, adds the 'abort' input. abort=1 in WRITE or DONE
//              returns to IDLE on the next edge, suppresses the strobe and done,
//              and drops a beat accepted on that same edge. Ignored in IDLE.
//              When undefined, a range ends only on completion or reset.
//
// Ports:
//   clk         in   1       rising-edge clock
//   reset       in   1       asynchronous, active-high reset
//   start       in   1       begin a range; sampled only in IDLE
//   start_addr  in   ADDR_W  first address; latched on accepted start
//   n           in   CNT_W   number of words; latched on accepted start
//   abort       in   1       (ABORT_EN only) abandon current range
//   in_data     in   DATA_W  stream data
//   in_valid    in   1       stream data valid
//   in_ready    out  1       high in WRITE; decoded from the state register only
//   mem_addr    out  ADDR_W  registered write address
//   mem_wdata   out  DATA_W  registered write data
//   mem_we      out  1       registered write strobe, one cycle per word
//   busy        out  1       state != IDLE
//   done        out  1       registered one-cycle completion pulse
// -----------------------------------------------------------------------------
module mem_range_writer #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [CNT_W-1:0]  n,
`ifdef ABORT_EN
  input  logic              abort,
`endif
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Registered state
  logic [1:0]        state_r;
  logic [ADDR_W-1:0] cur_addr_r;
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  len_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic              mem_we_r;
  logic              done_r;

  // Next-state values
  logic [1:0]        state_nxt_s;
  logic [ADDR_W-1:0] cur_addr_nxt_s;
  logic [CNT_W-1:0]  count_nxt_s;
  logic [CNT_W-1:0]  len_nxt_s;
  logic [ADDR_W-1:0] mem_addr_nxt_s;
  logic [DATA_W-1:0] mem_wdata_nxt_s;
  logic              mem_we_nxt_s;
  logic              done_nxt_s;

  logic              ready_s;
  logic              beat_s;
  logic              last_beat_s;
  logic              abort_s;

  // Address increment; the natural ADDR_W-bit overflow provides the wrap.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction

`ifdef ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  assign ready_s = (state_r == ST_WRITE);
  assign beat_s  = in_valid & ready_s;

  // len_r is never zero while in WRITE, but the guard keeps len-1 from being
  // meaningful for an empty range.
  assign last_beat_s = (len_r != {CNT_W{1'b0}}) && (count_r == (len_r - CNT_W'(1)));

  // Next-state and datapath decisions for every register.
  always_comb begin
    state_nxt_s     = state_r;
    cur_addr_nxt_s  = cur_addr_r;
    count_nxt_s     = count_r;
    len_nxt_s       = len_r;
    mem_addr_nxt_s  = mem_addr_r;
    mem_wdata_nxt_s = mem_wdata_r;
    mem_we_nxt_s    = 1'b0;
    done_nxt_s      = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          cur_addr_nxt_s = start_addr;
          len_nxt_s      = n;
          count_nxt_s    = {CNT_W{1'b0}};
          if (n == {CNT_W{1'b0}}) begin
            // Empty range: complete immediately, done visible during DONE.
            state_nxt_s = ST_DONE;
            done_nxt_s  = 1'b1;
          end else begin
            state_nxt_s = ST_WRITE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end

      ST_WRITE: begin
        if (abort_s) begin
          // Abort wins over a same-edge beat and over last-beat completion.
          state_nxt_s = ST_IDLE;
        end else if (beat_s) begin
          mem_addr_nxt_s  = cur_addr_r;
          mem_wdata_nxt_s = in_data;
          mem_we_nxt_s    = 1'b1;
          cur_addr_nxt_s  = next_addr(cur_addr_r);
          count_nxt_s     = count_r + CNT_W'(1);
          if (last_beat_s) begin
            // done rises on the same edge as the final strobe.
            state_nxt_s = ST_DONE;
            done_nxt_s  = 1'b1;
          end else begin
            state_nxt_s = ST_WRITE;
          end
        end else begin
          state_nxt_s = ST_WRITE;
        end
      end

      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end

      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      cur_addr_r  <= {ADDR_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      len_r       <= {CNT_W{1'b0}};
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
      mem_we_r    <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cur_addr_r  <= cur_addr_nxt_s;
      count_r     <= count_nxt_s;
      len_r       <= len_nxt_s;
      mem_addr_r  <= mem_addr_nxt_s;
      mem_wdata_r <= mem_wdata_nxt_s;
      mem_we_r    <= mem_we_nxt_s;
      done_r      <= done_nxt_s;
    end
  end

  assign in_ready  = ready_s;
  assign busy      = (state_r != ST_IDLE);
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign mem_we    = mem_we_r;
  assign done      = done_r;

endmodule

// File: tb/tb_mem_range_writer.sv
// -----------------------------------------------------------------------------
// tb_mem_range_writer
//
// Self-checking bench for mem_range_writer. Inputs are driven and outputs are
// sampled on the falling edge. Expected outputs come from a range-level model:
// after a start the writer is ready until n beats are taken; beat k goes to
// start_addr+k (mod 256); the last beat carries done; one DONE cycle follows.
// -----------------------------------------------------------------------------
module tb_mem_range_writer;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] start_addr;
  logic [7:0] n;
  logic [7:0] in_data;
  logic       in_valid;
`ifdef ABORT_EN
  logic       abort;
`endif
  logic       in_ready;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic       busy;
  logic       done;

  int total;
  int bad;

  mem_range_writer #(.ADDR_W(8), .DATA_W(8), .CNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .start_addr (start_addr),
    .n          (n),
`ifdef ABORT_EN
    .abort      (abort),
`endif
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one range from the IDLE falling edge to the IDLE falling edge after
  // DONE, checking every cycle against the range model.
  //   vmode 0: in_valid always 1; 1: random; 2: pattern bits pat[0..plen-1]
  //   noise: keep start high with random start_addr/n while busy
  //   hold : leave start high at return (next range back-to-back)
  task automatic drive_range(input logic [7:0] sa, input logic [7:0] nn,
                             input int vmode, input logic [15:0] pat, input int plen,
                             input bit seq_data, input bit noise, input bit hold,
                             input string tag);
    logic [7:0] acc;
    logic [7:0] exp_addr;
    logic [7:0] exp_wdata;
    logic [7:0] d;
    logic       exp_we, exp_done, exp_busy, exp_ready;
    bit         v;
    bit         finished;
    int         cyc;
    start      = 1'b1;
    start_addr = sa;
    n          = nn;
    in_valid   = 1'($urandom_range(0, 1));
    in_data    = 8'($urandom);
    @(posedge clk);
    acc       = 8'd0;
    cyc       = 0;
    v         = 1'b0;
    finished  = 1'b0;
    exp_busy  = 1'b1;
    exp_we    = 1'b0;
    exp_done  = (nn == 8'd0);
    exp_ready = (nn != 8'd0);
    exp_addr  = 8'd0;
    exp_wdata = 8'd0;
    for (int guard = 0; guard < 4000; guard++) begin
      @(negedge clk);
      total++;
      if (busy !== exp_busy) begin
        bad++;
        $display("FAIL %s busy cyc=%0d: got %b exp %b", tag, cyc, busy, exp_busy);
      end
      total++;
      if (in_ready !== exp_ready) begin
        bad++;
        $display("FAIL %s in_ready cyc=%0d: got %b exp %b", tag, cyc, in_ready, exp_ready);
      end
      total++;
      if (mem_we !== exp_we) begin
        bad++;
        $display("FAIL %s mem_we cyc=%0d: got %b exp %b", tag, cyc, mem_we, exp_we);
      end
      total++;
      if (done !== exp_done) begin
        bad++;
        $display("FAIL %s done cyc=%0d: got %b exp %b", tag, cyc, done, exp_done);
      end
      if (exp_we) begin
        total++;
        if (mem_addr !== exp_addr) begin
          bad++;
          $display("FAIL %s mem_addr cyc=%0d: got %h exp %h", tag, cyc, mem_addr, exp_addr);
        end
        total++;
        if (mem_wdata !== exp_wdata) begin
          bad++;
          $display("FAIL %s mem_wdata cyc=%0d: got %h exp %h", tag, cyc, mem_wdata, exp_wdata);
        end
      end
      if (finished) begin
        start = hold ? 1'b1 : 1'b0;
        break;
      end
      // Drive the next cycle.
      if (hold || noise) begin
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (noise) begin
        start_addr = 8'($urandom);
        n          = 8'($urandom);
      end
      if (exp_ready) begin
        if (vmode == 0)      v = 1'b1;
        else if (vmode == 1) v = 1'($urandom_range(0, 1));
        else                 v = pat[cyc % plen];
        d = seq_data ? (8'hA0 + acc) : 8'($urandom);
      end else begin
        v = 1'($urandom_range(0, 1));
        d = 8'($urandom);
      end
      in_valid = v;
      in_data  = d;
      @(posedge clk);
      // Model update for what that edge did.
      if (!exp_ready) begin
        exp_busy = 1'b0;
        exp_done = 1'b0;
        exp_we   = 1'b0;
        finished = 1'b1;
      end else if (v) begin
        exp_we    = 1'b1;
        exp_addr  = sa + acc;
        exp_wdata = d;
        acc       = acc + 8'd1;
        if (acc == nn) begin
          exp_done  = 1'b1;
          exp_ready = 1'b0;
        end
      end else begin
        exp_we = 1'b0;
      end
      cyc++;
    end
    if (!finished) begin
      total++;
      bad++;
      $display("FAIL %s timeout: got unfinished exp finished", tag);
    end
  endtask

  task automatic test_reset;
    total++;
    if ({busy, in_ready, mem_we, done} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags: got %b exp 0000", {busy, in_ready, mem_we, done});
    end
    total++;
    if ({mem_addr, mem_wdata} !== 16'h0000) begin
      bad++;
      $display("FAIL reset_data: got %h exp 0000", {mem_addr, mem_wdata});
    end
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({busy, mem_we, done} !== 3'b000) begin
      bad++;
      $display("FAIL reset_idle: got %b exp 000", {busy, mem_we, done});
    end
  endtask

  task automatic test_basic;
    drive_range(8'h10, 8'd4, 0, 16'h0000, 1, 1'b1, 1'b0, 1'b0, "basic");
  endtask

  task automatic test_wrap;
    drive_range(8'hFE, 8'd4, 0, 16'h0000, 1, 1'b0, 1'b0, 1'b0, "wrap");
  endtask

  task automatic test_zero;
    drive_range(8'h33, 8'd0, 0, 16'h0000, 1, 1'b0, 1'b0, 1'b0, "zero");
  endtask

  task automatic test_stall;
    // in_valid sequence 1,0,0,1,0,1
    drive_range(8'h50, 8'd3, 2, 16'h0029, 6, 1'b0, 1'b0, 1'b0, "stall");
  endtask

  task automatic test_async_reset;
    start      = 1'b1;
    start_addr = 8'h20;
    n          = 8'd5;
    in_valid   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h01;
    @(posedge clk);
    @(negedge clk);
    in_data = 8'h02;
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({mem_we, done, mem_addr, mem_wdata} !== {1'b1, 1'b0, 8'h21, 8'h02}) begin
      bad++;
      $display("FAIL areset_pre: got %b%b %h %h exp 10 21 02", mem_we, done, mem_addr, mem_wdata);
    end
    in_data = 8'h03;
    #1 reset = 1'b1;
    #1;
    total++;
    if ({busy, in_ready, mem_we, done, mem_addr, mem_wdata} !== 20'h00000) begin
      bad++;
      $display("FAIL areset_now: got %b%b%b%b %h %h exp all zero",
               busy, in_ready, mem_we, done, mem_addr, mem_wdata);
    end
    @(posedge clk);
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    total++;
    if ({busy, mem_we, done} !== 3'b000) begin
      bad++;
      $display("FAIL areset_hold: got %b exp 000", {busy, mem_we, done});
    end
    drive_range(8'h40, 8'd2, 0, 16'h0000, 1, 1'b0, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_restart_ignored;
    drive_range(8'h30, 8'd6, 1, 16'h0000, 1, 1'b0, 1'b1, 1'b0, "restart");
  endtask

  task automatic test_back_to_back;
    drive_range(8'h80, 8'd3, 0, 16'h0000, 1, 1'b0, 1'b0, 1'b1, "b2b_a");
    drive_range(8'h90, 8'd2, 1, 16'h0000, 1, 1'b0, 1'b0, 1'b1, "b2b_b");
    drive_range(8'hA0, 8'd0, 0, 16'h0000, 1, 1'b0, 1'b0, 1'b0, "b2b_c");
  endtask

  task automatic test_long;
    drive_range(8'($urandom), 8'd255, 0, 16'h0000, 1, 1'b0, 1'b0, 1'b0, "long");
  endtask

  task automatic test_random;
    for (int i = 0; i < 25; i++) begin
      drive_range(8'($urandom), 8'($urandom_range(0, 12)), 1, 16'h0000, 1, 1'b0,
                  1'($urandom_range(0, 1)), (i != 24) && ($urandom_range(0, 1) == 1),
                  "random");
    end
  endtask

`ifdef ABORT_EN
  task automatic test_abort;
    start      = 1'b1;
    start_addr = 8'h60;
    n          = 8'd4;
    in_valid   = 1'b0;
    abort      = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h11;
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({mem_we, mem_addr, mem_wdata, busy} !== {1'b1, 8'h60, 8'h11, 1'b1}) begin
      bad++;
      $display("FAIL abort_first: got %b %h %h %b exp 1 60 11 1", mem_we, mem_addr, mem_wdata, busy);
    end
    abort   = 1'b1;
    in_data = 8'h22;
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({busy, in_ready, mem_we, done} !== 4'b0000) begin
      bad++;
      $display("FAIL abort_stop: got %b exp 0000", {busy, in_ready, mem_we, done});
    end
    abort = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({busy, mem_we, done} !== 3'b000) begin
      bad++;
      $display("FAIL abort_after: got %b exp 000", {busy, mem_we, done});
    end
    in_valid   = 1'b0;
    abort      = 1'b1;
    start      = 1'b1;
    start_addr = 8'h70;
    n          = 8'd2;
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({busy, in_ready} !== 2'b11) begin
      bad++;
      $display("FAIL abort_idle_ignored: got %b exp 11", {busy, in_ready});
    end
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({busy, mem_we, done} !== 3'b000) begin
      bad++;
      $display("FAIL abort_write: got %b exp 000", {busy, mem_we, done});
    end
    abort = 1'b0;
  endtask
`endif

  initial begin
    total      = 0;
    bad        = 0;
    reset      = 1'b1;
    start      = 1'b0;
    start_addr = 8'h00;
    n          = 8'h00;
    in_data    = 8'h00;
    in_valid   = 1'b0;
`ifdef ABORT_EN
    abort      = 1'b0;
`endif
    repeat (2) @(negedge clk);
    test_reset();
    test_basic();
    test_wrap();
    test_zero();
    test_stall();
    test_async_reset();
    test_restart_ignored();
    test_back_to_back();
    test_long();
    test_random();
`ifdef ABORT_EN
    test_abort();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
